// File: rtl/booth_mult.sv
// booth_mult: sequential signed WIDTH x WIDTH multiplier, radix-2 Booth.
// One recode/add/shift step per clock. The product is published to
// hi_out/lo_out only on completion, together with a one-cycle mult_stop.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mult_init,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_stop,
    output logic             busy
);

    // Counter must be able to hold the value WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [WIDTH:0]     acc_r;      // one guard bit so acc - (-2^(WIDTH-1)) fits
    logic [WIDTH:0]     m_r;        // sign-extended multiplicand
    logic [WIDTH-1:0]   q_r;        // multiplier, shifts out as product low half
    logic               q_m1_r;     // Booth "Q-1" bit
    logic               steps_done_s;
    logic [2*WIDTH+1:0] step_s;

    // One Booth step: recode {Q[0],Q-1}, add/subtract M modulo 2^(WIDTH+1),
    // then arithmetic shift of {acc,Q,Q-1} right by one. Returns the shifted
    // {acc,Q,Q-1} vector.
    function automatic logic [2*WIDTH+1:0] booth_step(
        input logic [WIDTH:0]   acc,
        input logic [WIDTH:0]   m,
        input logic [WIDTH-1:0] q,
        input logic             q_m1
    );
        logic [WIDTH:0] sum;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        // Dropping the old Q-1 and replicating the sign bit is the shift.
        booth_step = {sum[WIDTH], sum, q};
    endfunction

    assign steps_done_s = (count_r == {CNT_W{1'b0}});
    assign step_s       = booth_step(acc_r, m_r, q_r, q_m1_r);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: start only from IDLE, one DONE cycle, then back.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (mult_init) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (steps_done_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: operand capture on accept, one Booth step per RUN edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            acc_r   <= {(WIDTH+1){1'b0}};
            m_r     <= {(WIDTH+1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            q_m1_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mult_init) begin
                        m_r     <= {a_in[WIDTH-1], a_in};
                        q_r     <= b_in;
                        acc_r   <= {(WIDTH+1){1'b0}};
                        q_m1_r  <= 1'b0;
                        count_r <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    if (!steps_done_s) begin
                        acc_r   <= step_s[2*WIDTH+1:WIDTH+1];
                        q_r     <= step_s[WIDTH:1];
                        q_m1_r  <= step_s[0];
                        count_r <= count_r - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs: product published only when entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_out    <= {WIDTH{1'b0}};
            lo_out    <= {WIDTH{1'b0}};
            mult_stop <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if ((state_r == RUN) && steps_done_s) begin
                hi_out    <= acc_r[WIDTH-1:0];
                lo_out    <= q_r;
                mult_stop <= 1'b1;
            end else begin
                mult_stop <= 1'b0;
            end
            busy <= (state_next_s != IDLE);
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: the driver pushes expected products
// (with their accept edge) into a queue; a monitor pops on mult_stop and
// checks value, latency, busy and output stability every cycle.
module tb_booth_mult;

    localparam int W   = 32;
    localparam int LAT = W + 1;       // accept edge to completion edge
    localparam int GAP = W + 3;       // accept-to-accept with init held high

    typedef struct {
        logic [63:0] prod;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  a_in, b_in;
    logic          mult_init;
    logic [W-1:0]  hi_out, lo_out;
    logic          mult_stop, busy;

    exp_t          sb[$];
    int            stop_cycles[$];
    int            cyc = 0;
    int            total = 0;
    int            passed = 0;
    int            stops_seen = 0;
    int            stops_exp = 0;
    bit            mon_en = 1'b0;
    logic [63:0]   last_prod = 64'd0;

    booth_mult #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .mult_init(mult_init), .hi_out(hi_out), .lo_out(lo_out),
        .mult_stop(mult_stop), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    task automatic push(input logic [63:0] prod, input int acc);
        exp_t e;
        e.prod = prod;
        e.acc  = acc;
        sb.push_back(e);
        stops_exp++;
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);   // DONE -> IDLE edge
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] prod);
        a_in      = a;
        b_in      = b;
        mult_init = 1'b1;
        push(prod, cyc + 1);
        @(negedge clk);
        mult_init = 1'b0;
        a_in      = $urandom;
        b_in      = $urandom;
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] prod);
        wait_idle();
        start(a, b, prod);
        wait_idle();
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        logic busy_exp;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                busy_exp = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc <= sb[0].acc + LAT);
                chk("busy", busy, busy_exp);
                if (mult_stop) begin
                    stops_seen++;
                    stop_cycles.push_back(cyc);
                    if (sb.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_stop: got mult_stop=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("product", {hi_out, lo_out}, e.prod);
                        chk("latency", cyc - e.acc, LAT);
                        last_prod = e.prod;
                    end
                end else begin
                    chk("hold", {hi_out, lo_out}, last_prod);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] corner [6];
        logic [W-1:0] ra, rb;
        int           e0;
        int           n;

        corner[0] = 32'h8000_0000; corner[1] = 32'h7FFF_FFFF;
        corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h0000_0000;
        corner[4] = 32'h0000_0001; corner[5] = 32'h8000_0001;

        reset = 1'b1; mult_init = 1'b0; a_in = 32'd0; b_in = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_stop", mult_stop, 1'b0);
        mon_en = 1'b1;

        // Directed products with hand-computed results.
        do_op(32'd7, 32'd3, 64'h0000_0000_0000_0015);
        do_op(32'hFFFF_FFFB, 32'd6, 64'hFFFF_FFFF_FFFF_FFE2);
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        do_op(32'd0, 32'h1234_5678, 64'd0);

        // Start request mid-run with new operands is ignored.
        start(32'd7, 32'd3, 64'h15);
        repeat (9) @(negedge clk);
        a_in = 32'd100; b_in = 32'd100; mult_init = 1'b1;
        @(negedge clk);
        mult_init = 1'b0;
        wait_idle();

        // Start request during the DONE cycle is ignored.
        start(32'd2, 32'd3, 64'd6);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        mult_init = 1'b1;
        @(negedge clk);
        mult_init = 1'b0;
        wait_idle();

        // Reset mid-operation: aborts, clears outputs, no completion.
        start(32'd7, 32'd3, 64'h15);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        stops_exp--;
        last_prod = 64'd0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_out", {hi_out, lo_out}, 64'd0);
        do_op(32'd2, 32'd2, 64'd4);

        // mult_init held high: back-to-back operations.
        a_in = 32'd7; b_in = 32'd3; mult_init = 1'b1;
        e0 = cyc + 1;
        push(64'h15, e0);
        push(64'h15, e0 + GAP);
        stop_cycles.delete();
        n = 0;
        while (cyc < e0 + GAP && n < 200) begin
            @(negedge clk);
            n++;
        end
        mult_init = 1'b0;
        wait_idle();
        if (stop_cycles.size() == 2) chk("b2b_gap", stop_cycles[1] - stop_cycles[0], GAP);
        else chk("b2b_count", stop_cycles.size(), 2);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(ra, rb, ref_mul(ra, rb));
        end

        chk("stop_count", stops_seen, stops_exp);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
